// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a qualified byte stream into 32-bit LE words behind a small FWFT FIFO
module byte_word_packer #(
  parameter int DEPTH = 4,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    data_in,
  input  logic          valid_in,
  input  logic          flush,
  output logic [31:0]   word_out,
  output logic [2:0]    word_bytes,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic [7:0]    drop_count
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   acc_q, acc_d, word_d;
  logic [2:0]    bytes_d;
  logic [31:0]   mem_q [DEPTH];
  logic [2:0]    nb_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q;
  logic [7:0]    drop_q;
  logic          push, pop, push_ok;
  assign word_valid = level_q != '0;
  always_comb begin
    word_d  = acc_q | (valid_in ? ({24'd0, data_in} << {cnt_q, 3'b000}) : 32'd0);
    bytes_d = {1'b0, cnt_q} + {2'b00, valid_in};
    push    = (valid_in && cnt_q == 2'd3) || (flush && (cnt_q != 2'd0 || valid_in));
    pop     = word_valid && word_ready;
    push_ok = push && (level_q != LW'(DEPTH) || pop);
    cnt_d   = push ? 2'd0 : cnt_q + {1'b0, valid_in};
    acc_d   = push ? 32'd0 : word_d;
    level_d = level_q + LW'(push_ok) - LW'(pop);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      level_q <= level_d;
      if (push_ok) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wp_q] <= word_d;
      nb_q[wp_q]  <= bytes_d;
    end
  end
  assign word_out   = word_valid ? mem_q[rp_q] : 32'd0;
  assign word_bytes = word_valid ? nb_q[rp_q] : 3'd0;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer: directed checks of packing, flush, FIFO full/drop and async reset
module tb_byte_word_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in = '0;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;
  logic        word_ready = 1'b0;
  logic [31:0] word_out;
  logic [2:0]  word_bytes;
  logic        word_valid;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_w [6];

  byte_word_packer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .flush(flush),
    .word_out(word_out), .word_bytes(word_bytes), .word_valid(word_valid),
    .word_ready(word_ready), .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    valid_in = 1'b1;
    data_in = b;
    step();
    valid_in = 1'b0;
  endtask

  task automatic drain(input int n, input string tag);
    word_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_w%0d", tag, k), word_out, exp_w[k]);
      check($sformatf("%s_b%0d", tag, k), {29'd0, word_bytes}, 32'd4);
      step();
    end
    check({tag, "_empty"}, {29'd0, level}, 32'd0);
    word_ready = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst_valid", {31'd0, word_valid}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_word", word_out, 32'd0);
    check("rst_bytes", {29'd0, word_bytes}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);
    reset = 1'b1;
    step();
    // basic word, consumer always ready
    word_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("basic_word", word_out, 32'h44332211);
    check("basic_bytes", {29'd0, word_bytes}, 32'd4);
    check("basic_valid", {31'd0, word_valid}, 32'd1);
    check("basic_level", {29'd0, level}, 32'd1);
    step();
    check("basic_pop", {29'd0, level}, 32'd0);
    check("basic_pop_v", {31'd0, word_valid}, 32'd0);
    // partial flush, then idle flush
    word_ready = 1'b0;
    send(8'hAA); send(8'hBB);
    flush = 1'b1; step(); flush = 1'b0;
    check("flush2_word", word_out, 32'h0000BBAA);
    check("flush2_bytes", {29'd0, word_bytes}, 32'd2);
    check("flush2_level", {29'd0, level}, 32'd1);
    word_ready = 1'b1; step(); word_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    check("idle_flush_level", {29'd0, level}, 32'd0);
    check("idle_flush_valid", {31'd0, word_valid}, 32'd0);
    // flush with completing byte
    send(8'h01); send(8'h02); send(8'h03);
    flush = 1'b1; send(8'hCC); flush = 1'b0;
    check("flush4_word", word_out, 32'hCC030201);
    check("flush4_bytes", {29'd0, word_bytes}, 32'd4);
    step();
    check("flush4_single", {29'd0, level}, 32'd1);
    word_ready = 1'b1; step(); word_ready = 1'b0;
    flush = 1'b1; send(8'h5A); flush = 1'b0;
    check("flush1_word", word_out, 32'h0000005A);
    check("flush1_bytes", {29'd0, word_bytes}, 32'd1);
    check("flush1_level", {29'd0, level}, 32'd1);
    word_ready = 1'b1; step(); word_ready = 1'b0;
    check("flush1_pop", {29'd0, level}, 32'd0);
    // full FIFO with a pop coinciding with the completing push
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    check("full_level", {29'd0, level}, 32'd4);
    check("full_ovf", {31'd0, overflow}, 32'd0);
    send(8'h90); send(8'h91); send(8'h92);
    word_ready = 1'b1; send(8'h93); word_ready = 1'b0;
    check("pushpop_level", {29'd0, level}, 32'd4);
    check("pushpop_ovf", {31'd0, overflow}, 32'd0);
    check("pushpop_drop", {24'd0, drop_count}, 32'd0);
    exp_w[0] = 32'h87868584; exp_w[1] = 32'h8B8A8988;
    exp_w[2] = 32'h8F8E8D8C; exp_w[3] = 32'h93929190;
    drain(4, "pushpop");
    // overflow: 6 words into a 4-deep FIFO
    for (int i = 0; i < 24; i++) send(8'(i + 1));
    check("ovf_level", {29'd0, level}, 32'd4);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_drop", {24'd0, drop_count}, 32'd2);
    exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605;
    exp_w[2] = 32'h0C0B0A09; exp_w[3] = 32'h100F0E0D;
    drain(4, "ovf");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    // asynchronous reset mid-operation
    for (int i = 0; i < 14; i++) send(8'(8'h40 + i));
    check("prerst_level", {29'd0, level}, 32'd3);
    reset = 1'b0;
    #1;
    check("arst_level", {29'd0, level}, 32'd0);
    check("arst_valid", {31'd0, word_valid}, 32'd0);
    check("arst_word", word_out, 32'd0);
    check("arst_bytes", {29'd0, word_bytes}, 32'd0);
    check("arst_ovf", {31'd0, overflow}, 32'd0);
    check("arst_drop", {24'd0, drop_count}, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("postrst_quiet", {31'd0, word_valid}, 32'd0);
    send(8'h61); send(8'h62); send(8'h63);
    check("postrst_partial", {31'd0, word_valid}, 32'd0);
    send(8'h64);
    check("postrst_word", word_out, 32'h64636261);
    check("postrst_bytes", {29'd0, word_bytes}, 32'd4);
    check("postrst_level", {29'd0, level}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
